// File: rtl/tone_arbiter.sv
// Fixed-priority arbiter sharing one tone-generator phase step between requesters.
// Optional feature: define TONE_ARB_PREEMPT_EN to let higher-priority requests cut a playing tone.
module tone_arbiter #(
    parameter int num_req_p   = 4,
    parameter int width_p     = 32,
    parameter int dur_width_p = 8,
    parameter int tick_div_p  = 25000000,
    parameter int gap_ticks_p = 1
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_req_p-1:0]             req_valid_i,
    input  logic [num_req_p*width_p-1:0]     req_fstep_i,
    input  logic [num_req_p*dur_width_p-1:0] req_dur_i,
    output logic [num_req_p-1:0]             req_ready_o,
    output logic [num_req_p-1:0]             done_o,
    output logic [width_p-1:0]               fstep_o,
    output logic                             busy_o,
    output logic [$clog2(num_req_p)-1:0]     owner_o
);

    localparam int OW = $clog2(num_req_p);
    localparam int PW = $clog2(tick_div_p);
    localparam int DW = dur_width_p;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [PW-1:0] PRESC_LAST = PW'(tick_div_p - 1);
    localparam logic [DW-1:0] GAP_TICKS  = DW'(gap_ticks_p);

    function automatic logic [num_req_p-1:0] onehot(input logic [OW-1:0] idx);
        logic [num_req_p-1:0] one;
        one = {{(num_req_p-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    logic [1:0]           state_r;
    logic [width_p-1:0]   fstep_r;
    logic                 busy_r;
    logic [OW-1:0]        owner_r;
    logic [num_req_p-1:0] done_r;
    logic [PW-1:0]        presc_r;
    logic [DW-1:0]        ticks_r;

    logic                 win_valid_s;
    logic [OW-1:0]        win_idx_s;
    logic [width_p-1:0]   sel_fstep_s;
    logic [DW-1:0]        sel_dur_s;
    logic [DW-1:0]        dur_eff_s;
    logic                 accept_s;
    logic                 preempt_s;
    logic                 take_s;
    logic                 tick_end_s;
    logic                 last_s;

    // Lowest-index valid requester wins.
    always_comb begin
        win_valid_s = 1'b0;
        win_idx_s   = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                win_valid_s = 1'b1;
                win_idx_s   = OW'(i);
            end else begin
                win_valid_s = win_valid_s;
                win_idx_s   = win_idx_s;
            end
        end
    end

    assign sel_fstep_s = req_fstep_i[int'(win_idx_s)*width_p +: width_p];
    assign sel_dur_s   = req_dur_i[int'(win_idx_s)*dur_width_p +: dur_width_p];
    assign dur_eff_s   = (sel_dur_s == '0) ? DW'(1) : sel_dur_s;

    assign accept_s = !reset_i && (state_r == ST_IDLE) && win_valid_s;
`ifdef TONE_ARB_PREEMPT_EN
    assign preempt_s = !reset_i && (state_r == ST_PLAY) && win_valid_s && (win_idx_s < owner_r);
`else
    assign preempt_s = 1'b0;
`endif
    assign take_s = accept_s | preempt_s;

    assign tick_end_s = (presc_r == PRESC_LAST);
    assign last_s     = tick_end_s && (ticks_r == DW'(1));

    // A cut tone reports done in the same cycle as the preempting accept.
    assign req_ready_o = take_s ? onehot(win_idx_s) : '0;
    assign done_o      = done_r | (preempt_s ? onehot(owner_r) : '0);
    assign fstep_o     = fstep_r;
    assign busy_o      = busy_r;
    assign owner_o     = owner_r;

    // Playback state machine with shared prescaler/tick countdown for PLAY and GAP.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
            fstep_r <= '0;
            busy_r  <= 1'b0;
            owner_r <= '0;
            done_r  <= '0;
            presc_r <= '0;
            ticks_r <= '0;
        end else begin
            done_r <= '0;
            if (take_s) begin
                state_r <= ST_PLAY;
                fstep_r <= sel_fstep_s;
                busy_r  <= 1'b1;
                owner_r <= win_idx_s;
                presc_r <= '0;
                ticks_r <= dur_eff_s;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_PLAY: begin
                        if (last_s) begin
                            fstep_r <= '0;
                            done_r  <= onehot(owner_r);
                            presc_r <= '0;
                            if (gap_ticks_p == 0) begin
                                state_r <= ST_IDLE;
                                busy_r  <= 1'b0;
                                ticks_r <= '0;
                            end else begin
                                state_r <= ST_GAP;
                                ticks_r <= GAP_TICKS;
                            end
                        end else begin
                            presc_r <= tick_end_s ? '0 : presc_r + PW'(1);
                            ticks_r <= tick_end_s ? ticks_r - DW'(1) : ticks_r;
                        end
                    end
                    ST_GAP: begin
                        if (last_s) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            presc_r <= '0;
                            ticks_r <= '0;
                        end else begin
                            presc_r <= tick_end_s ? '0 : presc_r + PW'(1);
                            ticks_r <= tick_end_s ? ticks_r - DW'(1) : ticks_r;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        fstep_r <= '0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tone_arbiter.sv
// Directed bench for tone_arbiter: tick_div 4, one instance with gap 1 and one with gap 0.
module tb_tone_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [127:0] req_fstep;
    logic [31:0]  req_dur;

    logic [3:0]   ready, done;
    logic [31:0]  fstep;
    logic         busy;
    logic [1:0]   owner;

    logic [3:0]   d0_ready, d0_done;
    logic [31:0]  d0_fstep;
    logic         d0_busy;
    logic [1:0]   d0_owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tone_arbiter #(.num_req_p(4), .width_p(32), .dur_width_p(8), .tick_div_p(4), .gap_ticks_p(1)) dut (
        .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_fstep_i(req_fstep),
        .req_dur_i(req_dur), .req_ready_o(ready), .done_o(done), .fstep_o(fstep),
        .busy_o(busy), .owner_o(owner)
    );

    tone_arbiter #(.num_req_p(4), .width_p(32), .dur_width_p(8), .tick_div_p(4), .gap_ticks_p(0)) dut0 (
        .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_fstep_i(req_fstep),
        .req_dur_i(req_dur), .req_ready_o(d0_ready), .done_o(d0_done), .fstep_o(d0_fstep),
        .busy_o(d0_busy), .owner_o(d0_owner)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic set_req(input int idx, input logic [31:0] fs, input logic [7:0] du);
        req_fstep[idx*32 +: 32] = fs;
        req_dur[idx*8 +: 8]     = du;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 4'b0000;
        ticks(2);
        check_eq("rst_fstep", {32'd0, fstep}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_owner", {62'd0, owner}, 64'd0);
        check_eq("rst_ready", {60'd0, ready}, 64'd0);
        check_eq("rst_done", {60'd0, done}, 64'd0);
        check_eq("rst_d0_busy", {63'd0, d0_busy}, 64'd0);
        reset = 1'b0;
        #1;
    endtask

    int extra;

    initial begin
        reset     = 1'b1;
        req_valid = 4'b0000;
        req_fstep = '0;
        req_dur   = '0;

        // Single tone: req 2, dur 3 -> 12 play cycles, done, 4 gap cycles.
        do_reset();
        set_req(2, 32'h0000_1234, 8'd3);
        req_valid = 4'b0100;
        #1;
        check_eq("single_ready", {60'd0, ready}, 64'h4);
        tick();
        req_valid = 4'b0000;
        #1;
        check_eq("single_ready_off", {60'd0, ready}, 64'h0);
        check_eq("single_owner", {62'd0, owner}, 64'd2);
        for (int i = 0; i < 12; i++) begin
            check_eq("single_play_fstep", {32'd0, fstep}, 64'h1234);
            check_eq("single_play_busy", {63'd0, busy}, 64'd1);
            check_eq("single_play_done", {60'd0, done}, 64'h0);
            tick();
        end
        check_eq("single_done", {60'd0, done}, 64'h4);
        for (int i = 0; i < 4; i++) begin
            check_eq("single_gap_fstep", {32'd0, fstep}, 64'h0);
            check_eq("single_gap_busy", {63'd0, busy}, 64'd1);
            tick();
        end
        check_eq("single_idle_busy", {63'd0, busy}, 64'd0);
        check_eq("single_idle_done", {60'd0, done}, 64'h0);

        // Contention: req 1 beats req 3; req 3 served on IDLE re-entry.
        set_req(1, 32'h0000_0111, 8'd1);
        set_req(3, 32'h0000_0333, 8'd1);
        req_valid = 4'b1010;
        #1;
        check_eq("cont_ready1", {60'd0, ready}, 64'h2);
        tick();
        req_valid = 4'b1000;
        #1;
        check_eq("cont_fstep1", {32'd0, fstep}, 64'h111);
        check_eq("cont_owner1", {62'd0, owner}, 64'd1);
        check_eq("cont_wait_ready", {60'd0, ready}, 64'h0);
        ticks(4);
        check_eq("cont_done1", {60'd0, done}, 64'h2);
        ticks(4);
        check_eq("cont_ready3", {60'd0, ready}, 64'h8);
        tick();
        req_valid = 4'b0000;
        #1;
        check_eq("cont_fstep3", {32'd0, fstep}, 64'h333);
        check_eq("cont_owner3", {62'd0, owner}, 64'd3);
        ticks(8);
        check_eq("cont_idle", {63'd0, busy}, 64'd0);

        // dur=0 on req 0 plays exactly one tick.
        set_req(0, 32'h0000_0abc, 8'd0);
        req_valid = 4'b0001;
        #1;
        check_eq("dur0_ready", {60'd0, ready}, 64'h1);
        tick();
        req_valid = 4'b0000;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_eq("dur0_play", {32'd0, fstep}, 64'habc);
            tick();
        end
        check_eq("dur0_silent", {32'd0, fstep}, 64'h0);
        check_eq("dur0_done", {60'd0, done}, 64'h1);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done != 4'b0000) extra++;
        end
        check_eq("dur0_done_once", 64'(extra), 64'd0);

        // Reset during PLAY cycle 5 aborts silently; held request re-accepted.
        set_req(2, 32'h0000_0055, 8'd3);
        req_valid = 4'b0100;
        #1;
        check_eq("rstmid_ready", {60'd0, ready}, 64'h4);
        tick();
        ticks(4);
        check_eq("rstmid_playing", {32'd0, fstep}, 64'h55);
        reset = 1'b1;
        tick();
        check_eq("rstmid_fstep", {32'd0, fstep}, 64'h0);
        check_eq("rstmid_busy", {63'd0, busy}, 64'd0);
        check_eq("rstmid_done", {60'd0, done}, 64'h0);
        reset = 1'b0;
        #1;
        check_eq("rstmid_reaccept", {60'd0, ready}, 64'h4);
        tick();
        req_valid = 4'b0000;
        #1;
        check_eq("rstmid_replay", {32'd0, fstep}, 64'h55);
        check_eq("rstmid_rebusy", {63'd0, busy}, 64'd1);
        ticks(16);

        // Back-to-back with zero gap on dut0.
        do_reset();
        set_req(0, 32'h0000_0077, 8'd1);
        req_valid = 4'b0001;
        #1;
        check_eq("b2b_ready", {60'd0, d0_ready}, 64'h1);
        tick();
        check_eq("b2b_play", {32'd0, d0_fstep}, 64'h77);
        ticks(3);
        check_eq("b2b_play_last", {32'd0, d0_fstep}, 64'h77);
        tick();
        check_eq("b2b_silent", {32'd0, d0_fstep}, 64'h0);
        check_eq("b2b_done", {60'd0, d0_done}, 64'h1);
        check_eq("b2b_reready", {60'd0, d0_ready}, 64'h1);
        tick();
        check_eq("b2b_replay", {32'd0, d0_fstep}, 64'h77);
        req_valid = 4'b0000;

        // Preemption scenario: req 3 dur 10, req 0 raised at PLAY cycle 6.
        do_reset();
        set_req(3, 32'h0000_3333, 8'd10);
        set_req(0, 32'h0000_00f0, 8'd1);
        req_valid = 4'b1000;
        #1;
        check_eq("pre_ready3", {60'd0, ready}, 64'h8);
        tick();
        req_valid = 4'b0000;
        ticks(5);
        req_valid = 4'b0001;
        #1;
`ifdef TONE_ARB_PREEMPT_EN
        check_eq("pre_ready0", {60'd0, ready}, 64'h1);
        check_eq("pre_done3", {60'd0, done}, 64'h8);
        tick();
        req_valid = 4'b0000;
        #1;
        check_eq("pre_fstep0", {32'd0, fstep}, 64'hf0);
        check_eq("pre_owner0", {62'd0, owner}, 64'd0);
        check_eq("pre_done_clear", {60'd0, done}, 64'h0);
        ticks(4);
        check_eq("pre_done0", {60'd0, done}, 64'h1);
        ticks(4);
        check_eq("pre_idle", {63'd0, busy}, 64'd0);
`else
        check_eq("nopre_ready", {60'd0, ready}, 64'h0);
        check_eq("nopre_fstep6", {32'd0, fstep}, 64'h3333);
        for (int c = 7; c <= 40; c++) begin
            tick();
            check_eq("nopre_play", {32'd0, fstep}, 64'h3333);
            check_eq("nopre_nodone", {60'd0, done}, 64'h0);
        end
        tick();
        check_eq("nopre_done3", {60'd0, done}, 64'h8);
        check_eq("nopre_silent", {32'd0, fstep}, 64'h0);
        check_eq("nopre_owner3", {62'd0, owner}, 64'd3);
        ticks(4);
        check_eq("nopre_ready0", {60'd0, ready}, 64'h1);
        tick();
        req_valid = 4'b0000;
        #1;
        check_eq("nopre_fstep0", {32'd0, fstep}, 64'hf0);
        check_eq("nopre_owner0", {62'd0, owner}, 64'd0);
        ticks(8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
